// File: rtl/id_ex_issue.sv
// RV32 decode/issue register between ID and EX: decodes R/LW/SW/BEQ/BNE, interlocks load-use, handles stall/flush.
// Optional ITYPE_ALU_EN macro adds OP-IMM (ADDI/ANDI/ORI/XORI/SLLI/SRLI/SRAI) decode; otherwise 0010011 is illegal.
module id_ex_issue #(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [data_width-1:0] rs1_data,
  input  logic [data_width-1:0] rs2_data,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic [1:0]            alu_op,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic [data_width-1:0] operand_A,
  output logic [data_width-1:0] operand_B,
  output logic [data_width-1:0] store_data,
  output logic [data_width-1:0] imm,
  output logic [4:0]            rd,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  branch,
  output logic                  out_valid,
  output logic                  illegal_instr
);

  logic [6:0]            opcode_s;
  logic [2:0]            f3_s;
  logic [4:0]            rs1_idx_s;
  logic [4:0]            rs2_idx_s;
  logic [4:0]            rd_idx_s;
  logic [data_width-1:0] imm_i_s;
  logic [data_width-1:0] imm_st_s;
  logic [data_width-1:0] imm_b_s;

  logic                  dec_legal_s;
  logic                  dec_uses_rs2_s;
  logic [1:0]            dec_alu_op_s;
  logic [6:0]            dec_funct7_s;
  logic [data_width-1:0] dec_a_s;
  logic [data_width-1:0] dec_b_s;
  logic [data_width-1:0] dec_store_s;
  logic [data_width-1:0] dec_imm_s;
  logic [4:0]            dec_rd_s;
  logic                  dec_reg_write_s;
  logic                  dec_mem_read_s;
  logic                  dec_mem_write_s;
  logic                  dec_branch_s;

  logic                  load_use_s;
  logic                  update_s;
  logic                  issue_s;
  logic                  illegal_s;

  assign opcode_s  = instr[6:0];
  assign f3_s      = instr[14:12];
  assign rs1_idx_s = instr[19:15];
  assign rs2_idx_s = instr[24:20];
  assign rd_idx_s  = instr[11:7];
  assign imm_i_s   = {{(data_width-12){instr[31]}}, instr[31:20]};
  assign imm_st_s  = {{(data_width-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b_s   = {{(data_width-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  // Instruction decode into the issue-register payload
  always_comb begin
    dec_legal_s     = 1'b0;
    dec_uses_rs2_s  = 1'b0;
    dec_alu_op_s    = 2'b00;
    dec_funct7_s    = 7'd0;
    dec_a_s         = '0;
    dec_b_s         = '0;
    dec_store_s     = '0;
    dec_imm_s       = '0;
    dec_rd_s        = 5'd0;
    dec_reg_write_s = 1'b0;
    dec_mem_read_s  = 1'b0;
    dec_mem_write_s = 1'b0;
    dec_branch_s    = 1'b0;
    case (opcode_s)
      7'b0110011: begin
        dec_legal_s     = 1'b1;
        dec_uses_rs2_s  = 1'b1;
        dec_alu_op_s    = 2'b10;
        dec_funct7_s    = instr[31:25];
        dec_a_s         = rs1_data;
        dec_b_s         = rs2_data;
        dec_rd_s        = rd_idx_s;
        dec_reg_write_s = 1'b1;
      end
      7'b0000011: begin
        if (f3_s == 3'b010) begin
          dec_legal_s     = 1'b1;
          dec_a_s         = rs1_data;
          dec_b_s         = imm_i_s;
          dec_imm_s       = imm_i_s;
          dec_rd_s        = rd_idx_s;
          dec_reg_write_s = 1'b1;
          dec_mem_read_s  = 1'b1;
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      7'b0100011: begin
        if (f3_s == 3'b010) begin
          dec_legal_s     = 1'b1;
          dec_uses_rs2_s  = 1'b1;
          dec_a_s         = rs1_data;
          dec_b_s         = imm_st_s;
          dec_imm_s       = imm_st_s;
          dec_store_s     = rs2_data;
          dec_mem_write_s = 1'b1;
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      7'b1100011: begin
        if ((f3_s == 3'b000) || (f3_s == 3'b001)) begin
          dec_legal_s    = 1'b1;
          dec_uses_rs2_s = 1'b1;
          dec_alu_op_s   = 2'b01;
          dec_a_s        = rs1_data;
          dec_b_s        = rs2_data;
          dec_imm_s      = imm_b_s;
          dec_branch_s   = 1'b1;
        end else begin
          dec_legal_s = 1'b0;
        end
      end
`ifdef ITYPE_ALU_EN
      7'b0010011: begin
        dec_legal_s     = 1'b1;
        dec_alu_op_s    = 2'b10;
        // Only the shifts carry a meaningful funct7 (SRAI vs SRLI)
        if ((f3_s == 3'b001) || (f3_s == 3'b101)) begin
          dec_funct7_s = instr[31:25];
        end else begin
          dec_funct7_s = 7'd0;
        end
        dec_a_s         = rs1_data;
        dec_b_s         = imm_i_s;
        dec_imm_s       = imm_i_s;
        dec_rd_s        = rd_idx_s;
        dec_reg_write_s = 1'b1;
      end
`endif
      default: begin
        dec_legal_s = 1'b0;
      end
    endcase
  end

  // Issue control: flush > ex_stall > load-use > normal issue
  always_comb begin
    load_use_s = in_valid && out_valid && mem_read && (rd != 5'd0) &&
                 ((rd == rs1_idx_s) || ((rd == rs2_idx_s) && dec_uses_rs2_s));
    update_s   = flush || !ex_stall;
    issue_s    = 1'b0;
    illegal_s  = 1'b0;
    in_ready   = 1'b0;
    if (!rst_n) begin
      in_ready = 1'b0;
    end else if (flush) begin
      in_ready = 1'b1;
    end else if (ex_stall) begin
      in_ready = 1'b0;
    end else if (load_use_s) begin
      in_ready = 1'b0;
    end else begin
      in_ready  = in_valid;
      issue_s   = in_valid && dec_legal_s;
      illegal_s = in_valid && !dec_legal_s;
    end
  end

  // Issue register; non-issuing updates load a bubble with every control cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      illegal_instr <= 1'b0;
      alu_op        <= 2'b00;
      funct3        <= 3'd0;
      funct7        <= 7'd0;
      operand_A     <= '0;
      operand_B     <= '0;
      store_data    <= '0;
      imm           <= '0;
      rd            <= 5'd0;
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      branch        <= 1'b0;
    end else if (update_s) begin
      out_valid     <= issue_s;
      illegal_instr <= illegal_s;
      alu_op        <= issue_s ? dec_alu_op_s    : 2'b00;
      funct3        <= issue_s ? f3_s            : 3'd0;
      funct7        <= issue_s ? dec_funct7_s    : 7'd0;
      operand_A     <= issue_s ? dec_a_s         : '0;
      operand_B     <= issue_s ? dec_b_s         : '0;
      store_data    <= issue_s ? dec_store_s     : '0;
      imm           <= issue_s ? dec_imm_s       : '0;
      rd            <= issue_s ? dec_rd_s        : 5'd0;
      reg_write     <= issue_s ? dec_reg_write_s : 1'b0;
      mem_read      <= issue_s ? dec_mem_read_s  : 1'b0;
      mem_write     <= issue_s ? dec_mem_write_s : 1'b0;
      branch        <= issue_s ? dec_branch_s    : 1'b0;
    end else begin
      // Held during EX stall; the illegal flag stays a single-cycle pulse
      illegal_instr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed self-checking bench for id_ex_issue (checks follow ITYPE_ALU_EN when defined).
module tb_id_ex_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        ex_stall;
  logic        flush;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic [31:0] store_data;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        out_valid;
  logic        illegal_instr;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_issue #(.data_width(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_stall(ex_stall), .flush(flush), .alu_op(alu_op), .funct3(funct3),
    .funct7(funct7), .operand_A(operand_A), .operand_B(operand_B),
    .store_data(store_data), .imm(imm), .rd(rd), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .out_valid(out_valid), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    instr    = ins;
    rs1_data = a;
    rs2_data = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_alu_op", {30'd0, alu_op}, 32'd0);
    check("rst_illegal", {31'd0, illegal_instr}, 32'd0);
    #9;
    rst_n = 1'b1;

    // ADD x3,x1,x2
    #1;
    check("add_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_alu_op", {30'd0, alu_op}, 32'd2);
    check("add_funct3", {29'd0, funct3}, 32'd0);
    check("add_funct7", {25'd0, funct7}, 32'd0);
    check("add_A", operand_A, 32'd5);
    check("add_B", operand_B, 32'd7);
    check("add_rd", {27'd0, rd}, 32'd3);
    check("add_reg_write", {31'd0, reg_write}, 32'd1);

    // LW x5,-4(x1) followed by dependent ADD x6,x5,x2
    drive(1'b1, 32'hFFC0A283, 32'd100, 32'd0);
    tick();
    check("lw_valid", {31'd0, out_valid}, 32'd1);
    check("lw_mem_read", {31'd0, mem_read}, 32'd1);
    check("lw_rd", {27'd0, rd}, 32'd5);
    check("lw_B", operand_B, 32'hFFFFFFFC);
    check("lw_alu_op", {30'd0, alu_op}, 32'd0);
    drive(1'b1, 32'h00228333, 32'd11, 32'd22);
    #1;
    check("lu_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
    check("lu_bubble_rw", {31'd0, reg_write}, 32'd0);
    check("lu_bubble_mr", {31'd0, mem_read}, 32'd0);
    check("lu_in_ready2", {31'd0, in_ready}, 32'd1);
    tick();
    check("lu_add_valid", {31'd0, out_valid}, 32'd1);
    check("lu_add_rd", {27'd0, rd}, 32'd6);
    check("lu_add_A", operand_A, 32'd11);
    check("lu_add_B", operand_B, 32'd22);

    // SW x2,8(x1)
    drive(1'b1, 32'h0020A423, 32'h100, 32'hDEADBEEF);
    tick();
    check("sw_alu_op", {30'd0, alu_op}, 32'd0);
    check("sw_B", operand_B, 32'd8);
    check("sw_A", operand_A, 32'h100);
    check("sw_store", store_data, 32'hDEADBEEF);
    check("sw_mem_write", {31'd0, mem_write}, 32'd1);
    check("sw_reg_write", {31'd0, reg_write}, 32'd0);
    check("sw_rd", {27'd0, rd}, 32'd0);

    // BEQ x1,x2,-8
    drive(1'b1, 32'hFE208CE3, 32'd1, 32'd2);
    tick();
    check("beq_alu_op", {30'd0, alu_op}, 32'd1);
    check("beq_imm", imm, 32'hFFFFFFF8);
    check("beq_branch", {31'd0, branch}, 32'd1);
    check("beq_rd", {27'd0, rd}, 32'd0);
    check("beq_reg_write", {31'd0, reg_write}, 32'd0);

    // EX stall for 3 cycles, then flush while stalled
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
    tick();
    drive(1'b1, 32'h0020A423, 32'h100, 32'h55);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_rd", {27'd0, rd}, 32'd3);
      check("stall_A", operand_A, 32'd5);
      check("stall_mem_write", {31'd0, mem_write}, 32'd0);
    end
    flush = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_rw", {31'd0, reg_write}, 32'd0);
    flush = 1'b0; ex_stall = 1'b0;

    // ADDI x1,x0,5: legal only with ITYPE_ALU_EN
    drive(1'b1, 32'h00500093, 32'd0, 32'd0);
    #1;
    check("addi_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
`ifdef ITYPE_ALU_EN
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_alu_op", {30'd0, alu_op}, 32'd2);
    check("addi_B", operand_B, 32'd5);
    check("addi_rd", {27'd0, rd}, 32'd1);
    check("addi_illegal", {31'd0, illegal_instr}, 32'd0);
`else
    check("addi_valid", {31'd0, out_valid}, 32'd0);
    check("addi_illegal", {31'd0, illegal_instr}, 32'd1);
    check("addi_rw", {31'd0, reg_write}, 32'd0);
`endif
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_illegal", {31'd0, illegal_instr}, 32'd0);

    // Reset asserted in the middle of a stall
    drive(1'b1, 32'h002081B3, 32'd9, 32'd4);
    tick();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    ex_stall = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_A", operand_A, 32'd0);
    check("mid_rst_rd", {27'd0, rd}, 32'd0);
    check("mid_rst_rw", {31'd0, reg_write}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    ex_stall = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_rd", {27'd0, rd}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_issue.md
ID_EX_ISSUE -- requirements
Module: id_ex_issue

Interface
REQ-001 SHALL have parameter data_width, default 32, width of operands and immediates.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  fetched instruction present.
REQ-005 SHALL have port in_ready  output  1  instruction consumed this cycle (combinational).
REQ-006 SHALL have port instr  input  32  RV32 instruction word.
REQ-007 SHALL have ports rs1_data, rs2_data  input  data_width  register file read data for instr[19:15], instr[24:20].
REQ-008 SHALL have port ex_stall  input  1  EX stage cannot accept; hold outputs.
REQ-009 SHALL have port flush  input  1  branch redirect; kill the instruction being issued.
REQ-010 SHALL have ports alu_op  output  2, funct3  output  3, funct7  output  7  registered ALU controls.
REQ-011 SHALL have ports operand_A, operand_B, store_data, imm  output  data_width  registered operands and sign-extended immediate.
REQ-012 SHALL have ports rd  output  5, reg_write, mem_read, mem_write, branch  output  1 each  registered controls.
REQ-013 SHALL have ports out_valid  output  1  registered issue valid; illegal_instr  output  1  one-cycle registered pulse.

Function
REQ-014 SHALL decode: R 0110011 -> alu_op 10, funct3/funct7 from instr, A=rs1, B=rs2, reg_write=1.
REQ-015 SHALL decode: LW 0000011/funct3 010 -> alu_op 00, B=I-imm, mem_read=1, reg_write=1, funct7=0.
REQ-016 SHALL decode: SW 0100011/funct3 010 -> alu_op 00, B=S-imm, store_data=rs2, mem_write=1, funct7=0.
REQ-017 SHALL decode: BEQ/BNE 1100011/funct3 000/001 -> alu_op 01, A=rs1, B=rs2, imm=B-imm, branch=1, funct7=0.
REQ-018 SHALL sign-extend all immediates from bit 31 to data_width; rd output 0 for SW and branches.
REQ-019 SHALL treat any other opcode/funct3 as illegal: consume it (in_ready=1), issue bubble, pulse illegal_instr next cycle.
REQ-020 SHALL detect load-use: out_valid & mem_read & rd!=0 & (rd==rs1 or (rd==rs2 and instr uses rs2)) with in_valid.
REQ-021 SHALL on load-use drive in_ready=0 and register a bubble (out_valid=0, all controls 0) for exactly one cycle.
REQ-022 SHALL priority: flush > ex_stall > load-use > normal issue.
REQ-023 SHALL on flush register a bubble and drive in_ready=1 (instruction dropped), even during ex_stall.
REQ-024 SHALL on ex_stall (no flush) hold all registered outputs and drive in_ready=0.
REQ-025 SHALL on normal issue with in_valid=0 register a bubble; latency instr to outputs is one cycle.
REQ-026 SHALL force reg_write=0 on bubbles so rd=0 writes never occur.

Reset
REQ-027 SHALL asynchronously clear on rst_n=0 all outputs to 0 (out_valid=0, illegal_instr=0, alu_op=00).
REQ-028 SHALL drive in_ready=0 while rst_n=0; first issue on the first edge after release.
REQ-029 SHALL drop any in-flight instruction on reset mid-stall; no state survives.

Configuration
REQ-030 SHALL with ITYPE_ALU_EN defined decode 0010011 (ADDI/ANDI/ORI/XORI/SLLI/SRLI/SRAI) as alu_op 10, B=I-imm, reg_write=1, funct7=instr[31:25] for shifts else 0000000, rs2 unused.
REQ-031 SHALL without ITYPE_ALU_EN treat 0010011 as illegal per REQ-019.

Verification
REQ-032 SHALL cover: ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle alu_op=10, funct3=000, funct7=0, A=5, B=7, rd=3, out_valid=1.
REQ-033 SHALL cover: LW x5,-4(x1) (0xFFC0A283) then ADD x6,x5,x2 -> bubble one cycle, in_ready=0 once, ADD issues next cycle.
REQ-034 SHALL cover: SW x2,8(x1) (0x0020A423), rs2=0xDEADBEEF -> alu_op=00, B=8, store_data=0xDEADBEEF, mem_write=1, reg_write=0.
REQ-035 SHALL cover: ex_stall=1 for 3 cycles during issue -> outputs unchanged, in_ready=0; flush asserted in stall -> out_valid=0 next cycle.
REQ-036 SHALL cover: 0x00500093 (ADDI x1,x0,5) -> with ITYPE_ALU_EN B=5, alu_op=10; without, out_valid=0, illegal_instr=1 one cycle.
REQ-037 SHALL cover: rst_n low mid-stall -> all outputs 0 immediately, no pending issue after release.
